// File: rtl/alu_op_sequencer_if.sv
// Request and response handshake channels between an issuer and the ALU op sequencer.
// The sequencer side uses the slave modport; the issuing/writeback side uses master.
interface alu_op_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic [4:0]            req_sel;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_carry;
  logic                  rsp_zero;
  logic                  rsp_ovf;
  logic                  rsp_neg;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_sel,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_carry,
    input  rsp_zero,
    input  rsp_ovf,
    input  rsp_neg,
    output rsp_ready
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_sel,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_carry,
    output rsp_zero,
    output rsp_ovf,
    output rsp_neg,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side controller for the combinational Cpu_Alu: sequences single requests and
// iterates the 1-bit SLL/ROR passes B[4:0] times, then returns result and flags.
module alu_op_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] SEL_SLL    = 5'b00111,
  parameter logic [4:0] SEL_ROR    = 5'b11001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_op_sequencer_if.slave     bus,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  input  logic                  alu_neg,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic       ready_en;
  logic       accept;
  logic       rsp_take;
  logic       zero_shift;

  function automatic logic is_shift(input logic [4:0] sel);
    return (sel == SEL_SLL) || (sel == SEL_ROR);
  endfunction

  function automatic logic [4:0] pass_count(input logic [4:0] sel,
                                            input logic [DATA_WIDTH-1:0] b);
    return is_shift(sel) ? b[4:0] : 5'd1;
  endfunction

  // ready_en keeps req_ready low until the first clock after reset release
  assign bus.req_ready = ready_en && (state == IDLE) && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rsp_take      = bus.rsp_valid && bus.rsp_ready;
  assign zero_shift    = is_shift(bus.req_sel) && (bus.req_b[4:0] == 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ready_en      <= 1'b0;
      busy          <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_ovf   <= 1'b0;
      bus.rsp_neg   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (rsp_take) begin
        bus.rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (zero_shift) begin
              // Zero-count shift bypasses the ALU; operand A is the result
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= bus.req_a;
              bus.rsp_carry <= 1'b0;
              bus.rsp_ovf   <= 1'b0;
              bus.rsp_zero  <= (bus.req_a == '0);
              bus.rsp_neg   <= bus.req_a[DATA_WIDTH-1];
            end else begin
              alu_a   <= bus.req_a;
              alu_b   <= bus.req_b;
              alu_sel <= bus.req_sel;
              cnt     <= pass_count(bus.req_sel, bus.req_b);
              state   <= EXEC;
              busy    <= 1'b1;
            end
          end
        end

        EXEC: begin
          // Each pass feeds the ALU result back as the next A operand
          alu_a <= alu_out;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= alu_out;
            bus.rsp_carry <= alu_carry;
            bus.rsp_zero  <= alu_zero;
            bus.rsp_ovf   <= alu_ovf;
            bus.rsp_neg   <= alu_neg;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural Cpu_Alu model on the alu_* side.
module tb_alu_op_sequencer;

  localparam logic [4:0] SEL_ADD = 5'b00000;
  localparam logic [4:0] SEL_SUB = 5'b00001;
  localparam logic [4:0] SEL_SLL = 5'b00111;
  localparam logic [4:0] SEL_ROR = 5'b11001;

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        zero;
    logic        ovf;
    logic        neg;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_sel;
  logic        alu_carry, alu_zero, alu_ovf, alu_neg;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  alu_op_sequencer_if #(.DATA_WIDTH(32)) bus ();

  alu_op_sequencer #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_carry(alu_carry),
    .alu_zero (alu_zero),
    .alu_ovf  (alu_ovf),
    .alu_neg  (alu_neg),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural Cpu_Alu: single-pass operations
  always_comb begin
    logic [32:0] s;
    s         = '0;
    alu_out   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_sel)
      SEL_ADD: begin
        s         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = s[31:0];
        alu_carry = s[32];
        alu_ovf   = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      SEL_SUB: begin
        s         = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out   = s[31:0];
        alu_carry = s[32];
        alu_ovf   = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      SEL_SLL: begin
        alu_out   = {alu_a[30:0], 1'b0};
        alu_carry = alu_a[31];
      end
      SEL_ROR: begin
        alu_out   = {alu_a[0], alu_a[31:1]};
        alu_carry = alu_a[0];
      end
      default: alu_out = alu_a & alu_b;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_neg  = alu_out[31];
  end

  function automatic exp_t mk(input logic [31:0] d, input logic c, input logic z,
                              input logic o, input logic n);
    exp_t e;
    e.data = d; e.carry = c; e.zero = z; e.ovf = o; e.neg = n; e.cyc = -1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request from posedge+1; returns at posedge+1 just after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel,
                       input exp_t e, input int lat, input bit push);
    int   guard;
    exp_t ee;
    guard = 0;
    ee    = e;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = sel;
    @(negedge clk);
    while (!bus.req_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(bus.req_ready), 32'd1);
    end else begin
      ee.cyc = (lat < 0) ? -1 : cyc + lat;
      if (push) sb.push_back(ee);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      guard++;
      step();
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: a response is consumed at the edge after a negedge with valid && ready
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_rsp: got data 0x%08h with no expected entry (cycle %0d)",
                 bus.rsp_data, cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.rsp_data !== e.data || bus.rsp_carry !== e.carry || bus.rsp_zero !== e.zero ||
            bus.rsp_ovf !== e.ovf || bus.rsp_neg !== e.neg) begin
          errors++;
          $display("FAIL rsp: got d=0x%08h c%0b z%0b o%0b n%0b expected d=0x%08h c%0b z%0b o%0b n%0b",
                   bus.rsp_data, bus.rsp_carry, bus.rsp_zero, bus.rsp_ovf, bus.rsp_neg,
                   e.data, e.carry, e.zero, e.ovf, e.neg);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp_latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int stale;
    int guard;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    step();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    step();

    // ADD overflow, then SUB issued as soon as the protocol allows
    issue(32'h7FFF_FFFF, 32'd1, SEL_ADD, mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1), 2, 1'b1);
    issue(32'd0, 32'd1, SEL_SUB, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1), 2, 1'b1);
    issue(32'h8000_0001, 32'd1, SEL_SLL, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0), 2, 1'b1);
    wait_drain();

    issue(32'h8000_0001, 32'd4, SEL_SLL, mk(32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0), 5, 1'b1);
    nb = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("sll4_busy_cycles", 32'(nb - 1), 32'd4);
    step();

    issue(32'd1, 32'd0, SEL_ROR, mk(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    issue(32'd1, 32'd1, SEL_ROR, mk(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1), 2, 1'b1);
    issue(32'd1, 32'h0000_0022, SEL_SLL, mk(32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0), 3, 1'b1);
    // Zero-count shifts back to back: ignored upper B bits, zero flag on zero data
    issue(32'd0, 32'd0, SEL_ROR, mk(32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0), 1, 1'b1);
    issue(32'd5, 32'h0000_0020, SEL_ROR, mk(32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    issue(32'hF000_0000, 32'h0000_0040, SEL_SLL, mk(32'hF000_0000, 1'b0, 1'b0, 1'b0, 1'b1), 1, 1'b1);
    wait_drain();

    // Backpressure: response held for three stalled cycles with the next request waiting
    bus.rsp_ready = 1'b0;
    issue(32'd1, 32'd2, SEL_ADD, mk(32'd3, 1'b0, 1'b0, 1'b0, 1'b0), -1, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_a     = 32'd5;
    bus.req_b     = 32'd6;
    bus.req_sel   = SEL_ADD;
    guard = 0;
    @(negedge clk);
    while (!bus.rsp_valid && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", bus.rsp_data, 32'd3);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    step();
    bus.rsp_ready = 1'b1;
    begin
      exp_t e2;
      e2 = mk(32'd11, 1'b0, 1'b0, 1'b0, 1'b0);
      e2.cyc = cyc + 2;
      sb.push_back(e2);
    end
    @(negedge clk);
    chk("bp_accept_on_handshake", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    wait_drain();

    // Reset during the 10th pass of a 31-pass shift
    issue(32'd1, 32'd31, SEL_SLL, mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0), -1, 1'b0);
    repeat (9) step();
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_alu_sel", 32'(alu_sel), 32'd0);
    step();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) stale++;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);
    step();

    issue(32'd2, 32'd3, SEL_ADD, mk(32'd5, 1'b0, 1'b0, 1'b0, 1'b0), 2, 1'b1);
    wait_drain();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
